// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_flow_ctrl : level / lives / enemy sequencing with frame-timed holds
// Revision 1.0
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int NUM_LEVELS  = 3,
  parameter int ENEMY_COUNT = 2,
  parameter int HIT_W       = 3,
  parameter int NUM_LIVES   = 3,
  parameter int TREE_BASE   = 6,
  parameter int TREE_STEP   = 2,
  parameter int HOLD_FRAMES = 60,
  localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             startGame,
  input  logic             playerDead,
  input  logic [HIT_W-1:0] shotEnemyCollision,
  output logic             pause,
  output logic [3:0]       tree_count,
  output logic [LVL_W-1:0] level,
  output logic [3:0]       enemies_left,
  output logic [2:0]       lives_left,
  output logic             start_screen,
  output logic             death_screen,
  output logic             victory_screen,
  output logic             level_start
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    START    = 3'd0,
    PLAY     = 3'd1,
    CLEAR    = 3'd2,
    RESPAWN  = 3'd3,
    VICTORY  = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             start_prev;
  logic [LVL_W-1:0] level_n;
  logic [3:0]       enemies_n;
  logic [2:0]       lives_n;
  logic [7:0]       kills;
  logic [3:0]       rem;

  // Sum is formed in 8 bits so large levels saturate instead of wrapping.
  function automatic logic [3:0] trees(input logic [LVL_W-1:0] lv);
    logic [7:0] t;
    t = 8'(TREE_BASE) + 8'(lv) * 8'(TREE_STEP);
    return (t > 8'd15) ? 4'd15 : t[3:0];
  endfunction

  always_comb begin
    state_n   = state;
    level_n   = level;
    enemies_n = enemies_left;
    lives_n   = lives_left;
    hold_n    = hold_cnt;
    kills     = '0;
    for (int i = 0; i < HIT_W; i++) kills = kills + 8'(shotEnemyCollision[i]);
    rem = (kills >= {4'd0, enemies_left}) ? 4'd0 : enemies_left - kills[3:0];

    case (state)
      START: if (startGame) begin
        state_n   = PLAY;
        level_n   = '0;
        lives_n   = 3'(NUM_LIVES);
        enemies_n = 4'(ENEMY_COUNT);
      end
      PLAY: begin
        enemies_n = rem;
        if (rem == 4'd0) begin
          state_n = (level == LVL_W'(NUM_LEVELS - 1)) ? VICTORY : CLEAR;
          hold_n  = '0;
        end else if (playerDead) begin
          lives_n = lives_left - 3'd1;
          state_n = (lives_left == 3'd1) ? GAMEOVER : RESPAWN;
          hold_n  = '0;
        end
      end
      CLEAR, RESPAWN, VICTORY: begin
        if (hold_cnt == HW'(HOLD_FRAMES)) begin
          if (state == CLEAR) begin
            state_n   = PLAY;
            level_n   = level + LVL_W'(1);
            enemies_n = 4'(ENEMY_COUNT);
          end else if (state == RESPAWN) begin
            state_n = PLAY;
          end else begin
            state_n = START;
          end
        end else if (startOfFrame) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      GAMEOVER: if (startGame && !start_prev) state_n = START;
      default: state_n = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= START;
      level          <= '0;
      enemies_left   <= 4'(ENEMY_COUNT);
      lives_left     <= 3'(NUM_LIVES);
      hold_cnt       <= '0;
      start_prev     <= 1'b0;
      level_start    <= 1'b0;
      pause          <= 1'b1;
      start_screen   <= 1'b1;
      death_screen   <= 1'b0;
      victory_screen <= 1'b0;
      tree_count     <= trees('0);
    end else begin
      state          <= state_n;
      level          <= level_n;
      enemies_left   <= enemies_n;
      lives_left     <= lives_n;
      hold_cnt       <= hold_n;
      start_prev     <= startGame;
      level_start    <= (state_n == PLAY) && (state != PLAY);
      pause          <= (state_n != PLAY);
      start_screen   <= (state_n == START);
      death_screen   <= (state_n == GAMEOVER);
      victory_screen <= (state_n == VICTORY);
      tree_count     <= trees(level_n);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// Bench for game_flow_ctrl: directed scenarios then random play against an event-level model.
module tb_game_flow_ctrl;

  localparam int NL = 3, EC = 2, LIVES = 3, HOLD = 60;
  localparam int M_START = 0, M_PLAY = 1, M_CLEAR = 2, M_RESP = 3, M_VIC = 4, M_GO = 5;

  logic       clk = 1'b0;
  logic       resetN = 1'b0, startOfFrame = 1'b0, startGame = 1'b0, playerDead = 1'b0;
  logic [2:0] shotEnemyCollision = 3'd0;
  logic       pause, start_screen, death_screen, victory_screen, level_start;
  logic [3:0] tree_count, enemies_left;
  logic [1:0] level;
  logic [2:0] lives_left;

  int checks = 0;
  int errors = 0;

  // model: phase, level, enemies, lives, frames still to wait, previous startGame, level_start
  int m_ph, m_lvl, m_en, m_lives, m_wait, m_prev, m_ls;

  game_flow_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .playerDead(playerDead), .shotEnemyCollision(shotEnemyCollision),
    .pause(pause), .tree_count(tree_count), .level(level), .enemies_left(enemies_left),
    .lives_left(lives_left), .start_screen(start_screen), .death_screen(death_screen),
    .victory_screen(victory_screen), .level_start(level_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic sof, input logic sg, input logic pd,
                       input logic [2:0] hit);
    int k;
    if (!rn) begin
      m_ph = M_START; m_lvl = 0; m_en = EC; m_lives = LIVES; m_wait = HOLD; m_prev = 0; m_ls = 0;
    end else begin
      m_ls = 0;
      case (m_ph)
        M_START: if (sg) begin
          m_ph = M_PLAY; m_lvl = 0; m_lives = LIVES; m_en = EC; m_ls = 1;
        end
        M_PLAY: begin
          k = $countones(hit);
          m_en = (k >= m_en) ? 0 : m_en - k;
          if (m_en == 0) begin
            m_ph = (m_lvl == NL - 1) ? M_VIC : M_CLEAR; m_wait = HOLD;
          end else if (pd) begin
            m_lives = m_lives - 1;
            m_ph = (m_lives == 0) ? M_GO : M_RESP; m_wait = HOLD;
          end
        end
        M_CLEAR, M_RESP, M_VIC: begin
          if (m_wait == 0) begin
            if (m_ph == M_CLEAR) begin m_lvl = m_lvl + 1; m_en = EC; end
            m_ls = (m_ph != M_VIC) ? 1 : 0;
            m_ph = (m_ph == M_VIC) ? M_START : M_PLAY;
          end else if (sof) begin
            m_wait = m_wait - 1;
          end
        end
        default: if (sg && m_prev == 0) m_ph = M_START;
      endcase
      m_prev = sg ? 1 : 0;
    end
  endtask

  task automatic check_all();
    int t;
    t = 6 + 2 * m_lvl;
    if (t > 15) t = 15;
    chk("pause",          8'(pause),          8'(m_ph != M_PLAY));
    chk("tree_count",     8'(tree_count),     8'(t));
    chk("level",          8'(level),          8'(m_lvl));
    chk("enemies_left",   8'(enemies_left),   8'(m_en));
    chk("lives_left",     8'(lives_left),     8'(m_lives));
    chk("start_screen",   8'(start_screen),   8'(m_ph == M_START));
    chk("death_screen",   8'(death_screen),   8'(m_ph == M_GO));
    chk("victory_screen", 8'(victory_screen), 8'(m_ph == M_VIC));
    chk("level_start",    8'(level_start),    8'(m_ls));
  endtask

  task automatic step(input logic rn, input logic sof, input logic sg, input logic pd,
                      input logic [2:0] hit);
    resetN = rn; startOfFrame = sof; startGame = sg; playerDead = pd; shotEnemyCollision = hit;
    @(posedge clk);
    model(rn, sof, sg, pd, hit);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic sg);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, sg, 1'b0, 3'd0);
  endtask

  task automatic frames(input int n, input logic sg);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, sg, 1'b0, 3'd0);
      idle(3, sg);
    end
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rst_start_screen", 8'(start_screen), 8'd1);
    chk("rst_tree", 8'(tree_count), 8'd6);
    chk("rst_lives", 8'(lives_left), 8'd3);
    idle(2, 1'b0);

    // start a game
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    chk("t1_level_start", 8'(level_start), 8'd1);
    chk("t1_pause", 8'(pause), 8'd0);
    chk("t1_tree", 8'(tree_count), 8'd6);
    idle(2, 1'b0);
    chk("t1_ls_pulse", 8'(level_start), 8'd0);

    // clear level 0 in one cycle, hold, advance to level 1
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    chk("t2_pause", 8'(pause), 8'd1);
    frames(59, 1'b0);
    chk("t2_still_hold", 8'(pause), 8'd1);
    frames(1, 1'b0);
    chk("t2_level", 8'(level), 8'd1);
    chk("t2_tree", 8'(tree_count), 8'd8);
    chk("t2_enemies", 8'(enemies_left), 8'd2);

    // kill and death together without clearing
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    chk("t3_enemies", 8'(enemies_left), 8'd1);
    chk("t3_lives", 8'(lives_left), 8'd2);
    frames(60, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    frames(60, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    chk("t4_death_screen", 8'(death_screen), 8'd1);
    chk("t4_lives", 8'(lives_left), 8'd0);
    idle(4, 1'b1);
    chk("t4_held_stays", 8'(death_screen), 8'd1);
    idle(1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    chk("t4_restart", 8'(start_screen), 8'd1);
    idle(1, 1'b0);

    // run through all three levels to victory
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    frames(60, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
    frames(60, 1'b0);
    chk("t5_level2", 8'(level), 8'd2);
    chk("t5_tree2", 8'(tree_count), 8'd10);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b111);
    chk("t5_victory", 8'(victory_screen), 8'd1);
    chk("t5_death_ignored", 8'(lives_left), 8'd3);
    frames(60, 1'b0);
    chk("t5_back_start", 8'(start_screen), 8'd1);

    // reset in the middle of a hold
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    frames(30, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t6_start", 8'(start_screen), 8'd1);
    chk("t6_level", 8'(level), 8'd0);
    chk("t6_lives", 8'(lives_left), 8'd3);

    // random play
    for (int c = 0; c < 5000; c++) begin
      step(($urandom_range(0, 699) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
